// File: rtl/l1_l2_block_xfer_buffer.sv
// Single-block staging buffer between the L1 arbitration mux and the L2 L1-facing port.
// Stages one victim block for write-back, or one fill block for L1 to drain word by word.
//
// state    | meaning
// IDLE     | waiting for an L1 block request
// WR_FILL  | collecting the L1 victim block, one word per write_en
// WR_REQ   | write-back request presented to L2
// WR_SEND  | streaming the staged block to L2
// RD_REQ   | fill request presented to L2
// RD_FILL  | capturing the returned fill words
// RD_DRAIN | handing fill words to L1, one per read_ack
module l1_l2_block_xfer_buffer #(
   parameter int BLOCK_WORDS = 16,
   parameter int ADDR_W      = 24,
   parameter int OFFSET_W    = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req_i,
   input  logic              rw_i,
   input  logic [ADDR_W-1:0] add_i,
   input  logic              write_en,
   input  logic              read_ack,
   input  logic [31:0]       data_i,
   output logic              ready_write_o,
   output logic              ready_read_o,
   output logic [31:0]       data_o,
   output logic              l2_req_o,
   output logic              l2_rw_o,
   output logic [ADDR_W-1:0] l2_add_o,
   output logic              l2_wvalid_o,
   output logic [31:0]       l2_data_o,
   input  logic              l2_ready_i,
   input  logic              l2_valid_i,
   input  logic [31:0]       l2_data_i,
   output logic [2:0]        exception_o
);

   typedef enum logic [2:0] {
      IDLE, WR_FILL, WR_REQ, WR_SEND, RD_REQ, RD_FILL, RD_DRAIN
   } state_t;

   localparam logic [OFFSET_W:0]  LAST_IDX  = (OFFSET_W+1)'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0]  ADDR_MASK = ~(ADDR_W'(BLOCK_WORDS - 1));

   state_t            state, nextState;
   logic [31:0]       blockBuf [BLOCK_WORDS];
   logic [OFFSET_W:0] cnt;
   logic [ADDR_W-1:0] blockAddr;
   logic [2:0]        excReg;
   logic              lastWord;
   logic              advance;
   logic [31:0]       bufWord;

   assign lastWord = (cnt == LAST_IDX);
   assign bufWord  = blockBuf[cnt[OFFSET_W-1:0]];

   always_ff @(posedge clock_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:     if (req_i) nextState = rw_i ? WR_FILL : RD_REQ;
         WR_FILL:  if (write_en && lastWord) nextState = WR_REQ;
         WR_REQ:   if (l2_ready_i) nextState = WR_SEND;
         WR_SEND:  if (l2_ready_i && lastWord) nextState = IDLE;
         RD_REQ:   if (l2_ready_i) nextState = RD_FILL;
         RD_FILL:  if (l2_valid_i && lastWord) nextState = RD_DRAIN;
         RD_DRAIN: if (read_ack && lastWord) nextState = IDLE;
         default:  nextState = IDLE;
      endcase
   end

   always_comb begin
      ready_write_o = 1'b0;
      ready_read_o  = 1'b0;
      data_o        = '0;
      l2_req_o      = 1'b0;
      l2_rw_o       = 1'b0;
      l2_wvalid_o   = 1'b0;
      l2_data_o     = '0;
      case (state)
         WR_FILL:  ready_write_o = 1'b1;
         WR_REQ:   begin l2_req_o = 1'b1; l2_rw_o = 1'b1; end
         WR_SEND:  begin l2_wvalid_o = 1'b1; l2_data_o = bufWord; end
         RD_REQ:   l2_req_o = 1'b1;
         RD_DRAIN: begin ready_read_o = 1'b1; data_o = bufWord; end
         default:  ;
      endcase
   end

   assign l2_add_o    = blockAddr;
   assign exception_o = excReg;

   // One word moves per cycle in whichever phase owns the counter.
   always_comb begin
      advance = 1'b0;
      case (state)
         WR_FILL:  advance = write_en;
         WR_SEND:  advance = l2_ready_i;
         RD_FILL:  advance = l2_valid_i;
         RD_DRAIN: advance = read_ack;
         default:  advance = 1'b0;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         cnt       <= '0;
         blockAddr <= '0;
         excReg    <= '0;
      end else begin
         if (state == IDLE && req_i) begin
            blockAddr <= add_i & ADDR_MASK;
            cnt       <= '0;
         end else if (advance) begin
            cnt <= lastWord ? '0 : cnt + 1'b1;
         end
         if (req_i && state != IDLE)        excReg[0] <= 1'b1;
         if (write_en && state != WR_FILL)  excReg[1] <= 1'b1;
         if (read_ack && state != RD_DRAIN) excReg[2] <= 1'b1;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         if (state == WR_FILL && write_en)
            blockBuf[cnt[OFFSET_W-1:0]] <= data_i;
         else if (state == RD_FILL && l2_valid_i)
            blockBuf[cnt[OFFSET_W-1:0]] <= l2_data_i;
      end
   end

endmodule

// File: tb/tb_l1_l2_block_xfer_buffer.sv
// Directed plus randomized bench for l1_l2_block_xfer_buffer; expected words come from
// per-transfer queues and the block/latency rules, not from the design's internals.
module tb_l1_l2_block_xfer_buffer;

   localparam int BW = 16;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        req_i, rw_i, write_en, read_ack;
   logic [23:0] add_i;
   logic [31:0] data_i;
   logic        ready_write_o, ready_read_o;
   logic [31:0] data_o;
   logic        l2_req_o, l2_rw_o, l2_wvalid_o;
   logic [23:0] l2_add_o;
   logic [31:0] l2_data_o;
   logic        l2_ready_i, l2_valid_i;
   logic [31:0] l2_data_i;
   logic [2:0]  exception_o;

   int vecs = 0;
   int errs = 0;

   l1_l2_block_xfer_buffer #(.BLOCK_WORDS(BW), .ADDR_W(24), .OFFSET_W(4)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .rw_i(rw_i), .add_i(add_i),
      .write_en(write_en), .read_ack(read_ack), .data_i(data_i),
      .ready_write_o(ready_write_o), .ready_read_o(ready_read_o), .data_o(data_o),
      .l2_req_o(l2_req_o), .l2_rw_o(l2_rw_o), .l2_add_o(l2_add_o),
      .l2_wvalid_o(l2_wvalid_o), .l2_data_o(l2_data_o),
      .l2_ready_i(l2_ready_i), .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i),
      .exception_o(exception_o)
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_ready_write"}, 32'(ready_write_o), 0);
      chk({tag, "_ready_read"},  32'(ready_read_o), 0);
      chk({tag, "_data_o"},      data_o, 0);
      chk({tag, "_l2_req"},      32'(l2_req_o), 0);
      chk({tag, "_l2_rw"},       32'(l2_rw_o), 0);
      chk({tag, "_l2_add"},      32'(l2_add_o), 0);
      chk({tag, "_l2_wvalid"},   32'(l2_wvalid_o), 0);
      chk({tag, "_l2_data"},     l2_data_o, 0);
      chk({tag, "_exception"},   32'(exception_o), 0);
   endtask

   // mode 0: directed data, L2 always ready; 1: random data and backpressure;
   // 2: random data, send-phase ready pattern 1,0,0,1 then steady.
   task automatic doWb(input logic [23:0] a, input int mode, input bit inj);
      logic [31:0] q[$];
      logic [31:0] d;
      int cyc, beats, sendCyc, guard;
      bit injDone;
      bit bpPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      req_i = 1; rw_i = 1; add_i = a;
      step();
      req_i = 0; rw_i = 0;
      cyc = 0;
      for (int i = 0; i < BW; i++) begin
         d = (mode == 0) ? 32'hA000_0000 + 32'(i) : $urandom;
         q.push_back(d);
         chk("wb_ready_write", 32'(ready_write_o), 1);
         write_en = 1; data_i = d;
         step(); cyc++;
      end
      write_en = 0; data_i = 0;
      chk("wb_ready_write_drop", 32'(ready_write_o), 0);
      beats = 0; sendCyc = 0; guard = 0; injDone = 0;
      while (beats < BW && guard < 400) begin
         guard++;
         if (l2_req_o) begin
            chk("wb_l2_rw", 32'(l2_rw_o), 1);
            chk("wb_l2_add", 32'(l2_add_o), 32'(a & 24'hFFFFF0));
            if (inj && !injDone) begin
               read_ack = 1; l2_ready_i = 0; injDone = 1;
            end else begin
               l2_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
         end else if (l2_wvalid_o) begin
            chk("wb_l2_data", l2_data_o, q[beats]);
            if (mode == 2)      l2_ready_i = (sendCyc < 4) ? bpPat[sendCyc] : 1'b1;
            else if (mode == 1) l2_ready_i = 1'($urandom_range(0, 1));
            else                l2_ready_i = 1'b1;
            sendCyc++;
            if (l2_ready_i) beats++;
         end else begin
            chk("wb_busy", 32'(l2_req_o | l2_wvalid_o), 1);
            guard = 400;
         end
         step(); cyc++;
         read_ack = 0;
      end
      l2_ready_i = 0;
      chk("wb_beats", 32'(beats), BW);
      chk("wb_done_idle", {29'b0, ready_write_o, l2_req_o, l2_wvalid_o}, 0);
      if (mode == 0) chk("wb_latency", 32'(cyc), 2 * BW + 1);
      if (mode == 2) chk("wb_bp_latency", 32'(cyc), 2 * BW + 1 + 2);
   endtask

   task automatic doFill(input logic [23:0] a, input int mode, input bit inj);
      logic [31:0] q[$];
      logic [31:0] d;
      int guard, gaps;
      bit accepted;
      req_i = 1; rw_i = 0; add_i = a;
      step();
      req_i = 0;
      accepted = 0; guard = 0;
      while (!accepted && guard < 50) begin
         guard++;
         chk("fill_l2_req", 32'(l2_req_o), 1);
         chk("fill_l2_rw", 32'(l2_rw_o), 0);
         chk("fill_l2_add", 32'(l2_add_o), 32'(a & 24'hFFFFF0));
         l2_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         accepted = l2_ready_i;
         step();
      end
      l2_ready_i = 0;
      chk("fill_req_dropped", 32'(l2_req_o), 0);
      for (int i = 0; i < BW; i++) begin
         gaps = (mode == 1) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : 1);
         repeat (gaps) begin
            chk("fill_no_ready_read", 32'(ready_read_o), 0);
            l2_data_i = $urandom;
            step();
         end
         d = (mode == 1) ? $urandom : 32'hB0 + 32'(i);
         q.push_back(d);
         chk("fill_no_ready_read", 32'(ready_read_o), 0);
         l2_valid_i = 1; l2_data_i = d;
         if (inj && i == 0) begin req_i = 1; rw_i = 1; end
         step();
         l2_valid_i = 0; req_i = 0; rw_i = 0; l2_data_i = $urandom;
      end
      for (int i = 0; i < BW; i++) begin
         repeat ((mode == 1) ? int'($urandom_range(0, 2)) : 0) begin
            chk("drain_hold_ready", 32'(ready_read_o), 1);
            chk("drain_hold_data", data_o, q[i]);
            step();
         end
         chk("drain_ready", 32'(ready_read_o), 1);
         chk("drain_data", data_o, q[i]);
         read_ack = 1;
         step();
         read_ack = 0;
      end
      chk("drain_done", {30'b0, ready_read_o, l2_req_o}, 0);
   endtask

   initial begin
      reset_i = 0; req_i = 0; rw_i = 0; add_i = 0; write_en = 0; read_ack = 0;
      data_i = 0; l2_ready_i = 0; l2_valid_i = 0; l2_data_i = 0;
      step(); step();
      chkAllZero("reset");
      reset_i = 1;

      doWb(24'h00123F, 0, 0);
      chk("exc_after_wb", 32'(exception_o), 0);
      doFill(24'h000045, 0, 0);
      chk("exc_after_fill", 32'(exception_o), 0);
      doWb(24'($urandom), 2, 0);

      // Protocol violations accumulate while the transfers still complete.
      write_en = 1; data_i = 32'hDEAD_BEEF;
      step();
      write_en = 0;
      chk("exc_write_idle", 32'(exception_o), 32'b010);
      doWb(24'($urandom), 1, 1);
      chk("exc_ack_wrreq", 32'(exception_o), 32'b110);
      doFill(24'($urandom), 1, 1);
      chk("exc_req_rdfill", 32'(exception_o), 32'b111);

      req_i = 1; rw_i = 1; add_i = 24'h00ABCD;
      step();
      req_i = 0;
      for (int i = 0; i < 5; i++) begin
         write_en = 1; data_i = $urandom;
         step();
      end
      write_en = 0;
      reset_i = 0;
      step();
      chkAllZero("midreset");
      reset_i = 1;
      doFill(24'($urandom), 1, 0);
      chk("exc_after_midreset", 32'(exception_o), 0);

      for (int n = 0; n < 6; n++) begin
         if ($urandom_range(0, 1) == 1) doWb(24'($urandom), 1, 0);
         else                           doFill(24'($urandom), 1, 0);
      end
      chk("exc_final", 32'(exception_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/l1_l2_block_xfer_buffer.md
Name: l1_l2_block_xfer_buffer

Overview:
- Single-block staging buffer between the L1 arbitration mux (selected L1I/L1D request, rw, address, write-enable, read-ack, data) and the L2 cache's L1-facing port.
- Write-backs: captures a full L1 victim block, then streams it to L2.
- Fills: issues a block read to L2, captures the returned words, then hands them to L1 one word per read-ack.
- Decouples L1 handshake timing from L2 latency. Single clock domain.

Parameters:
- BLOCK_WORDS, 16, words per cache block; power of two, 2..64.
- ADDR_W, 24, word-address width.
- OFFSET_W, 4, log2(BLOCK_WORDS).

Ports:
- clock_i  in  1  system clock; all state changes on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- req_i  in  1  L1 block request; sampled in IDLE only.
- rw_i  in  1  1 = write-back to L2, 0 = fill from L2.
- add_i  in  ADDR_W  L1 block word address.
- write_en  in  1  L1 pushes data_i into the buffer.
- read_ack  in  1  L1 consumes the word on data_o.
- data_i  in  32  L1 write-back word.
- ready_write_o  out  1  buffer accepts write_en this cycle.
- ready_read_o  out  1  data_o holds a valid fill word.
- data_o  out  32  fill word to L1.
- l2_req_o  out  1  block request to L2.
- l2_rw_o  out  1  request direction.
- l2_add_o  out  ADDR_W  block-aligned address.
- l2_wvalid_o  out  1  l2_data_o valid.
- l2_data_o  out  32  write-back word to L2.
- l2_ready_i  in  1  L2 accepts request or word.
- l2_valid_i  in  1  L2 fill word valid.
- l2_data_i  in  32  L2 fill word.
- exception_o  out  3  sticky error flags.

Behaviour:
- Reset (reset_i=0 at a clock edge):
  - state = IDLE; counters = 0; all outputs 0.
  - exception_o cleared.
  - Storage array is not cleared.
  - Reset mid-operation abandons the transfer; no further L2 activity.
- Storage: BLOCK_WORDS x 32 register array. Word counter cnt is OFFSET_W+1 bits.
- Request capture: when req_i=1 in IDLE, latch rw_i and {add_i[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, and set cnt=0.
  - rw_i=1 -> WR_FILL.
  - rw_i=0 -> RD_REQ.
- WR_FILL:
  - ready_write_o = 1.
  - Each write_en stores data_i at index cnt, then cnt++.
  - When the BLOCK_WORDS-th word is stored: cnt=0 and next state is WR_REQ.
  - ready_write_o drops the cycle after the last word.
- WR_REQ:
  - l2_req_o=1 and l2_rw_o=1, with l2_add_o held.
  - On l2_ready_i=1: l2_req_o drops next cycle; go to WR_SEND.
- WR_SEND:
  - l2_wvalid_o=1 and l2_data_o = buf[cnt].
  - Each cycle with l2_ready_i=1 transfers one word and cnt++.
  - After the last word: go to IDLE.
  - Stalls indefinitely while l2_ready_i=0.
- RD_REQ:
  - l2_req_o=1 and l2_rw_o=0.
  - On l2_ready_i=1: go to RD_FILL.
- RD_FILL:
  - Each l2_valid_i=1 stores l2_data_i at buf[cnt], then cnt++.
  - After the last word: cnt=0; go to RD_DRAIN.
  - l2_valid_i is ignored in all other states.
- RD_DRAIN:
  - ready_read_o=1 and data_o = buf[cnt] (combinational from cnt).
  - Each read_ack advances cnt.
  - read_ack on the last word: go to IDLE; ready_read_o=0 next cycle.
- Latency:
  - Minimum write-back is BLOCK_WORDS + 1 + BLOCK_WORDS cycles after capture.
  - Minimum fill-to-first-L1-word is 1 + L2 latency + BLOCK_WORDS cycles.
- Simultaneous events:
  - req_i outside IDLE is ignored and sets exception_o[0].
  - write_en outside WR_FILL is ignored and sets exception_o[1].
  - read_ack outside RD_DRAIN is ignored and sets exception_o[2].
  - Exceptions are sticky until reset.
- Only one block is in flight at a time. A request is accepted in IDLE the same cycle the previous transfer returns to IDLE + 1; no back-to-back overlap.

Test Plan:
- Write-back, BLOCK_WORDS=16:
  - Stimulus: req_i=1, rw_i=1, add_i=0x00123F; 16 write_en words 0xA000_0000..0xA000_000F; l2_ready_i held 1.
  - Required: l2_add_o=0x001230 with l2_rw_o=1; 16 l2_wvalid_o beats in order; ready_write_o=0 after word 16; IDLE after 34 cycles.
- Fill:
  - Stimulus: req_i=1, rw_i=0, add_i=0x000045; L2 returns 0xB0..0xBF on l2_valid_i with 1-cycle gaps.
  - Required: l2_add_o=0x000040; ready_read_o rises only after all 16 words; data_o sequence 0xB0..0xBF on successive read_acks.
- L2 backpressure:
  - Stimulus: in WR_SEND, l2_ready_i toggles 1,0,0,1.
  - Required: cnt advances only on ready cycles; l2_data_o stable during stalls.
- Protocol errors:
  - Stimulus: req_i during RD_FILL; write_en in IDLE; read_ack in WR_REQ.
  - Required: exception_o=3'b111; the transfer in progress completes unaffected.
- Reset mid-transfer:
  - Stimulus: reset_i=0 after 5 words of WR_FILL.
  - Required: all outputs 0 next edge; a new fill request then completes correctly, with cnt starting at 0.
